// File: rtl/key_filter_if.sv
// Key filter signal bundle: raw active-low keys in, press events and debounced levels out.
interface key_filter_if;
  logic [3:0] key_in;
  logic [3:0] key_out;
  logic [3:0] key_level;

  modport master (output key_in, input key_out, input key_level);
  modport slave  (input key_in, output key_out, output key_level);
endinterface

// File: rtl/key_filter.sv
// Four-key debouncer with one-hot press events; define KEY_FILTER_REPEAT_EN to add
// hold-to-repeat (first repeat after LONG_CYC held cycles, then every REPEAT_CYC).
module key_filter #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 50_000_000,
  parameter int REPEAT_CYC   = 10_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  key_filter_if.slave kif
);
  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_e;

  logic [3:0] sync1_r;
  logic [3:0] sync_r;
  logic [3:0] pend_r;
  logic [3:0] pend_set_s;
  logic [3:0] emit_s;
  logic [3:0] level_s;
  logic [3:0] level_r;
  logic [3:0] key_out_r;

  // Isolates the lowest set bit so only one event leaves per cycle.
  function automatic logic [3:0] lowest_one(input logic [3:0] v);
    lowest_one = v & (~v + 4'd1);
  endfunction

  for (genvar k = 0; k < 4; k++) begin : g_key
    state_e        state_r;
    state_e        state_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic          press_s;

    // Debounce state and stability counter.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_r <= IDLE;
        cnt_r   <= '0;
      end else begin
        state_r <= state_s;
        cnt_r   <= cnt_s;
      end
    end

    // Counter is only meaningful while checking, so every other path leaves it zero.
    always_comb begin
      state_s = state_r;
      cnt_s   = '0;
      press_s = 1'b0;
      case (state_r)
        IDLE: begin
          if (!sync_r[k]) state_s = PRESS_CHK;
          else            state_s = IDLE;
        end
        PRESS_CHK: begin
          if (sync_r[k]) begin
            state_s = IDLE;
          end else if (cnt_r == DEB_LAST) begin
            state_s = HELD;
            press_s = 1'b1;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        HELD: begin
          if (sync_r[k]) state_s = REL_CHK;
          else           state_s = HELD;
        end
        REL_CHK: begin
          if (!sync_r[k]) begin
            state_s = HELD;
          end else if (cnt_r == DEB_LAST) begin
            state_s = IDLE;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end

    assign level_s[k] = (state_s == HELD) || (state_s == REL_CHK);

`ifdef KEY_FILTER_REPEAT_EN
    localparam int HMAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
    localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYC - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYC - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    logic [HW-1:0] hold_r;
    logic          rep_r;
    logic          rep_fire_s;

    assign rep_fire_s = (state_r == HELD) && (state_s == HELD) &&
                        (hold_r == (rep_r ? REP_LAST : LONG_LAST));

    // Hold timer: runs only while staying in HELD; rep_r switches to the repeat period.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_r <= '0;
        rep_r  <= 1'b0;
      end else if ((state_r == HELD) && (state_s == HELD)) begin
        if (rep_fire_s) begin
          hold_r <= '0;
          rep_r  <= 1'b1;
        end else begin
          hold_r <= hold_r + HOLD_ONE;
          rep_r  <= rep_r;
        end
      end else begin
        hold_r <= '0;
        rep_r  <= 1'b0;
      end
    end

    assign pend_set_s[k] = press_s | rep_fire_s;
`else
    assign pend_set_s[k] = press_s;
`endif
  end

  always_comb begin
    emit_s = lowest_one(pend_r);
  end

  // Synchronizers reset to the released level; a newly set pending bit survives its own emit cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r   <= 4'b1111;
      sync_r    <= 4'b1111;
      pend_r    <= 4'b0000;
      level_r   <= 4'b0000;
      key_out_r <= 4'b0000;
    end else begin
      sync1_r   <= kif.key_in;
      sync_r    <= sync1_r;
      pend_r    <= (pend_r & ~emit_s) | pend_set_s;
      level_r   <= level_s;
      key_out_r <= emit_s;
    end
  end

  assign kif.key_out   = key_out_r;
  assign kif.key_level = level_r;
endmodule
